// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin share of one ROM read port between IF and LD.
//   mclk/reset            clock, async active-high reset
//   if_*/ld_*             req/addr/gnt request side, rvalid/rdata/err response side
//   rom_enable/address    issue to rom_memory; rom_data_in is its registered word
module rom_port_arbiter #(
  parameter int unsigned SIZE   = 64000,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              ld_err,
  output logic              rom_enable,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [31:0]       rom_data_in
);
  logic              last_ld, resp_v, resp_ld, resp_err, grant_any, ok;
  logic [ADDR_W-1:0] gaddr;
  // IF wins unless LD also asks and IF owned the port last
  assign if_gnt    = !reset && if_req && (!ld_req || last_ld);
  assign ld_gnt    = !reset && ld_req && !if_gnt;
  assign grant_any = if_gnt || ld_gnt;
  assign gaddr     = if_gnt ? if_addr : ld_addr;
  // full-width compare so high addresses cannot wrap into range
  assign ok          = gaddr[1:0] == 2'b00 && gaddr <= ADDR_W'(SIZE - 4);
  assign rom_enable  = grant_any && ok;
  assign rom_address = rom_enable ? gaddr : '0;
  always_ff @(posedge mclk or posedge reset)
    if (reset) begin
      last_ld  <= 1'b1;
      resp_v   <= 1'b0;
      resp_ld  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      resp_v   <= grant_any;
      resp_ld  <= ld_gnt;
      resp_err <= grant_any && !ok;
      if (grant_any) last_ld <= ld_gnt;
    end
  assign if_rvalid = resp_v && !resp_ld;
  assign ld_rvalid = resp_v && resp_ld;
  assign if_err    = if_rvalid && resp_err;
  assign ld_err    = ld_rvalid && resp_err;
  assign if_rdata  = (if_rvalid && !resp_err) ? rom_data_in : 32'h0;
  assign ld_rdata  = (ld_rvalid && !resp_err) ? rom_data_in : 32'h0;
endmodule
